// File: rtl/riscv_pkg.sv
// Shared constants for the data-memory responder: opcodes, load/store size
// encodings and the MMIO register map.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte offsets of the four MMIO words relative to the window base
    localparam logic [3:0] MMIO_LED  = 4'h0;
    localparam logic [3:0] MMIO_CNT  = 4'h4;
    localparam logic [3:0] MMIO_STAT = 4'h8;
    localparam logic [3:0] MMIO_RSVD = 4'hC;

endpackage

// File: rtl/riscv_dmem_responder_lsu_align.sv
// Combinational load/store alignment: byte-lane enables and shifted store
// data, misalignment detection, and load extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_lane_en,
    output logic [31:0] o_wdata,
    output logic        o_size_ok,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_bytes[gi] = i_rword[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_bytes[i_addr_lo];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_lane_en  = 4'b0000;
        o_wdata    = 32'd0;
        o_size_ok  = 1'b0;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_size_ok = 1'b1;
                o_lane_en = 4'b0001 << i_addr_lo;
                o_wdata   = {24'd0, i_wdata[7:0]} << {i_addr_lo, 3'b000};
            end
            F3_H: begin
                o_size_ok  = 1'b1;
                o_misalign = i_addr_lo[0];
                o_lane_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {16'd0, i_wdata[15:0]} << {i_addr_lo[1], 4'b0000};
            end
            F3_W: begin
                o_size_ok  = 1'b1;
                o_misalign = (i_addr_lo != 2'b00);
                o_lane_en  = 4'b1111;
                o_wdata    = i_wdata;
            end
            default: ;
        endcase
    end

    // Misaligned half/word loads fall through to the raw word
    always_comb begin
        o_rdata = i_rword;
        case (i_funct3)
            F3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU: o_rdata = {24'd0, w_byte};
            F3_H:  if (!i_addr_lo[0]) o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU: if (!i_addr_lo[0]) o_rdata = {16'd0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: byte-addressable RAM plus a 4-word MMIO window
// (LED, free-running cycle counter, status), with same-cycle read data.
module riscv_dmem_responder
    import riscv_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [31:0] InstrM,
    output logic [31:0] ReadData,
    output logic [7:0]  led_out,
    output logic        misalign_err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0] r_mem [MEM_WORDS];
    logic [7:0]  r_led;
    logic [31:0] r_cycle_cnt;
    logic        r_misalign_err;

    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic          w_in_ram;
    logic          w_in_mmio;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_mmio_rel;
    logic [1:0]    w_mmio_word;
    logic [31:0]   w_mmio_rword;
    logic [31:0]   w_rword;
    logic [31:0]   w_load_data;
    logic [3:0]    w_lane_en;
    logic [31:0]   w_wdata_sh;
    logic          w_size_ok;
    logic          w_misalign;
    logic          w_store;
    logic          w_store_ok;
    logic          w_ram_we;
    logic          w_led_we;
    logic          w_cnt_clr;
    logic          w_unused;

    assign w_opcode    = InstrM[6:0];
    assign w_funct3    = InstrM[14:12];
    assign w_in_ram    = (Mem_WrAddr < RAM_BYTES);
    assign w_in_mmio   = !w_in_ram && (Mem_WrAddr >= MMIO_BASE)
                         && (Mem_WrAddr < MMIO_BASE + 32'd16);
    assign w_ram_idx   = Mem_WrAddr[AW+1:2];
    assign w_mmio_rel  = Mem_WrAddr - MMIO_BASE;
    assign w_mmio_word = w_mmio_rel[3:2];
    assign w_unused    = ^{InstrM[31:15], InstrM[11:7], w_mmio_rel[31:4], w_mmio_rel[1:0]};

    lsu_align u_align (
        .i_funct3   (w_funct3),
        .i_addr_lo  (Mem_WrAddr[1:0]),
        .i_wdata    (Mem_WrData),
        .i_rword    (w_rword),
        .o_lane_en  (w_lane_en),
        .o_wdata    (w_wdata_sh),
        .o_size_ok  (w_size_ok),
        .o_misalign (w_misalign),
        .o_rdata    (w_load_data)
    );

    always_comb begin
        w_mmio_rword = 32'd0;
        case ({w_mmio_word, 2'b00})
            MMIO_LED:  w_mmio_rword = {24'd0, r_led};
            MMIO_CNT:  w_mmio_rword = r_cycle_cnt;
            MMIO_STAT: w_mmio_rword = {31'd0, r_misalign_err};
            MMIO_RSVD: w_mmio_rword = 32'd0;
            default:   w_mmio_rword = 32'd0;
        endcase
    end

    assign w_rword  = w_in_ram  ? r_mem[w_ram_idx] :
                      w_in_mmio ? w_mmio_rword     : 32'd0;
    assign ReadData = (w_opcode == OP_LOAD) ? w_load_data : w_rword;

    // A misaligned store is dropped everywhere; only the sticky flag records it
    assign w_store    = MemWriteM && w_size_ok && !reset;
    assign w_store_ok = w_store && !w_misalign;
    assign w_ram_we   = w_store_ok && w_in_ram;
    assign w_led_we   = w_store_ok && w_in_mmio && (w_mmio_word == 2'd0) && w_lane_en[0];
    assign w_cnt_clr  = w_store_ok && w_in_mmio && (w_mmio_word == 2'd1);

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led          <= 8'd0;
            r_cycle_cnt    <= 32'd0;
            r_misalign_err <= 1'b0;
        end else begin
            if (w_store && w_misalign) begin
                r_misalign_err <= 1'b1;
            end
            if (w_led_we) begin
                r_led <= w_wdata_sh[7:0];
            end
            r_cycle_cnt <= w_cnt_clr ? 32'd0 : r_cycle_cnt + 32'd1;
        end
    end

    assign led_out      = r_led;
    assign misalign_err = r_misalign_err;

endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
Data-memory responder at the far end of the CPU's memory-stage interface. It accepts the CPU's store strobe, address and write data, and returns ReadData in the same cycle. It decodes access size from the memory-stage instruction and implements byte/half/word stores with load extension. It also exposes a small MMIO window containing an LED register, a free-running cycle counter and a sticky misalignment flag.

Parameters:
MEM_WORDS, 256, RAM depth in 32-bit words; must be a power of two; byte range is 0 .. 4*MEM_WORDS-1.
MMIO_BASE, 32'h0000_1000, base byte address of the MMIO window (4 words).

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
MemWriteM  input  1  store strobe from the CPU memory stage
Mem_WrAddr  input  32  byte address for both loads and stores
Mem_WrData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
InstrM  input  32  memory-stage instruction; opcode = [6:0], funct3 = [14:12]
ReadData  output  32  load data, combinational from address, InstrM and current state
led_out  output  8  LED register
misalign_err  output  1  sticky store-misalignment flag

Behaviour:
- Interface: clk, reset; reset is synchronous and active-high; one clock domain.
- Reset values: led_out=0, cycle counter=0, misalign_err=0. RAM contents are not reset. While reset is high, all writes are suppressed, including writes to RAM.
- Store size comes from funct3: 000=SB, 001=SH, 010=SW. Any other funct3 with MemWriteM=1 is ignored and does not set any error.
- Byte lanes: SB writes lane addr[1:0]. SH writes lanes {addr[1],0}+{0,1}. SW writes all four lanes. Data is shifted into the addressed lane(s).
- Misalignment: SH with addr[0]=1, or SW with addr[1:0]!=0. The store is dropped, and misalign_err becomes 1 on the next edge. Only reset clears it.
- Store latency: 1 cycle. The write is visible to a combinational read in the cycle after the edge. A read in the same cycle as a store returns the old data.
- Load path: when opcode=0000011, ReadData is the extracted and extended value, using funct3 at the address's lane.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Misaligned LH/LHU/LW return the raw word at addr[31:2].
  - For a non-load opcode, ReadData is the raw word.
- Address decode:
  - RAM when addr < 4*MEM_WORDS; word index = addr[log2(MEM_WORDS)+1:2].
  - MMIO when MMIO_BASE <= addr < MMIO_BASE+16.
  - Anything else: stores are ignored and ReadData=0.
- MMIO map (word offsets):
  - +0: LED register, RW, bits [7:0]; upper bits read 0. Sub-word stores update only the lanes covering [7:0].
  - +4: cycle counter, 32-bit. Increments every cycle and wraps 0xFFFF_FFFF -> 0. Any aligned store writes 0 on the next edge; clear wins over increment.
  - +8: status, RO; bit0 = misalign_err. Writes are ignored.
  - +12: reserved; reads 0, writes ignored.
- Simultaneous events:
  - Reset beats everything.
  - A misaligned store to MMIO is dropped and flagged, not partially applied.
  - A store to the counter in the wrap cycle yields 0.

Decomposition:
- Shared package (riscv_pkg) holds:
  - Opcode constants OP_LOAD/OP_STORE.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - MMIO offset constants.
- Sub-module lsu_align (combinational):
  - Store side: lane-enable and shifted write data.
  - Load side: extract/extend.
  - Misalign detect.
- Top holds the RAM array, MMIO registers and address decode.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> 0xDEADBEEF. Then LB @0x13 -> 0xFFFFFFDE, LBU @0x13 -> 0x000000DE, LH @0x12 -> 0xFFFFDEAD.
- SB 0x5A @0x21 into a word holding 0x11223344 -> LW @0x20 = 0x11225A44. SH 0xBEEF @0x22 -> 0xBEEF5A44.
- SW @0x06 (misaligned) -> RAM unchanged, misalign_err=1 next cycle, status read @MMIO_BASE+8 = 1. Flag stays 1 until reset.
- Counter:
  - Release reset, read @MMIO_BASE+4 after 10 cycles -> 10.
  - Store to the counter -> reads 0 the cycle after, then counts up.
  - Force a wrap from 0xFFFFFFFF -> 0.
- SB 0xA5 @MMIO_BASE -> led_out=0xA5 next cycle. Assert reset with a simultaneous SW to RAM -> led_out=0 and the RAM word is unchanged.
- Load @0x0000_2000 (unmapped) -> ReadData=0. Store there -> no state change anywhere.
